dds_demod: RTL and testbench
============================

Name: dds_demod

Overview:
- Coherent integrate-and-dump demodulator for the DDS digital-modulation modes ASK, BPSK and QPSK.
- Consumes 12-bit signed received samples plus a locally generated, phase-aligned sine/cosine carrier from a second DDS instance.
- Correlates each sample with both carriers over one symbol and issues 1 or 2 recovered data bits per symbol.
- Sits at the receive end of the modem path; it is the inverse of the DDS modulator.

Parameters:
- SYMBOL_LEN, 300, valid samples per symbol (>=2).
- ACC_W, 40, signed accumulator width; must be >= 24 + clog2(SYMBOL_LEN) + 1.
- ASK_THRESH, 268435456, ASK decision threshold on |I|+|Q| at accumulator scale.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low, all state holds.
- mode  in  4  4'b1000 ASK, 4'b1010 BPSK, 4'b1100 QPSK; any other value is unsupported.
- sym_start  in  1  symbol-boundary strobe; the sample present in the same cycle is sample 0.
- sample_valid  in  1  qualifies wave, ref_sin and ref_cos.
- wave  in  12  signed received sample.
- ref_sin  in  12  signed local sine carrier.
- ref_cos  in  12  signed local cosine carrier.
- data_out  out  2  recovered symbol; bit 1 is unused (0) for ASK and BPSK.
- data_valid  out  1  one-cycle pulse qualifying data_out.
- mode_err  out  1  one-cycle pulse when a symbol was integrated under an unsupported mode.

Behaviour:
- Reset (rst=0, async): data_out=0, data_valid=0, mode_err=0; accumulators and counter cleared; FSM enters IDLE.
- Pipeline:
  - Stage 1 registers the 24-bit signed products pI=wave*ref_cos and pQ=wave*ref_sin, together with the valid flag and last/first tags.
  - Stage 2 sign-extends each product to ACC_W and accumulates into accI and accQ.
- FSM states:
  - IDLE: leave on en & sym_start & sample_valid -> INTEG. That sample is counted as sample 0 and mode is latched into mode_q.
  - INTEG: cnt increments on each sample_valid. The sample with cnt==SYMBOL_LEN-1 is tagged last and the FSM moves to DUMP.
  - DUMP: lasts 1 cycle and issues the decision. If sym_start & sample_valid arrive in this cycle, go to INTEG with a new symbol (cnt=1, mode re-latched); otherwise go to IDLE.
- Back-to-back symbols: sym_start must accompany sample 0 of every symbol. A sym_start in the DUMP cycle gives gapless streaming.
- Dump: when the last-tagged product reaches stage 2, the final sums I=accI+pI and Q=accQ+pQ are decided and the accumulators load 0. A first-tagged product instead loads directly, without adding.
- Latency: data_valid pulses exactly 2 clk cycles after the edge that samples the last wave value of the symbol.
- Decisions, taken on the full ACC_W-bit sums:
  - ASK: data_out = {1'b0, (|I|+|Q| >= ASK_THRESH)}. Absolute values saturate to ACC_W-1 bits.
  - BPSK: data_out = {1'b0, Q<0}. +sin carrier gives 0, -sin gives 1.
  - QPSK: data_out = {I<0, Q<0}. Bit 1 is the cos component sign, bit 0 the sin component sign; a negative component gives 1.
  - Unsupported mode_q: mode_err pulses instead of data_valid; data_out holds its previous value.
- mode changes mid-symbol are ignored until the next sym_start.
- sym_start mid-symbol (cnt!=0, not in DUMP) aborts the current symbol: no data_valid, counter restarts at 1, accumulator first-loads, mode re-latched.
- sample_valid low: the counter and accumulators hold and the pipeline bubbles propagate. Gaps do not change the sample count per symbol.
- en low: every register holds, including in-flight pipeline stages; data_valid and mode_err are forced low while en=0. On en rising, operation resumes exactly where it stopped.
- Reset asserted mid-symbol discards all partial results; no pulse is emitted.
- No accumulator overflow is possible with the legal ACC_W.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release without sym_start -> data_out=0, data_valid=0, mode_err=0 for 1000 cycles.
- BPSK pair: reference DDS drives sine/cosine; transmitter sends BPSK bits 0 then 1, 300 samples each, sym_start on each sample 0 -> data_out=2'b00 then 2'b01, each data_valid exactly 2 cycles after that symbol's 300th sample.
- QPSK all symbols: send symbols 0,1,2,3 back-to-back (gapless sym_start in DUMP) -> data_out sequence 0,1,2,3; exactly 4 data_valid pulses spaced 300 cycles apart.
- ASK: send bit 0 (zero amplitude) then bit 1 (full-scale 2047) -> 2'b00 then 2'b01. Also check |I|+|Q| ~6.3e8 for the on symbol.
- Disturbances:
  - sample_valid low for 50 cycles mid-symbol -> same decision; data_valid delayed by 50.
  - sym_start at sample 150 -> no output for the aborted symbol.
  - mode switched BPSK->QPSK at sample 100 -> the current symbol is decided as BPSK.
- Unsupported mode 4'b0011 latched -> single mode_err pulse; data_valid stays 0. Then rst pulse mid-symbol -> no pulse, outputs cleared immediately (asynchronously).

Source files
------------

// File: rtl/dds_demod.sv
// Coherent integrate-and-dump demodulator for ASK / BPSK / QPSK.
// Correlates each received sample against a phase-aligned local sin/cos pair.
module dds_demod #(
    parameter int     SYMBOL_LEN = 300,
    parameter int     ACC_W      = 40,
    parameter longint ASK_THRESH = 268435456
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         mode,
    input  logic               sym_start,
    input  logic               sample_valid,
    input  logic signed [11:0] wave,
    input  logic signed [11:0] ref_sin,
    input  logic signed [11:0] ref_cos,
    output logic [1:0]         data_out,
    output logic               data_valid,
    output logic               mode_err
);

    localparam int               CNT_W     = $clog2(SYMBOL_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SYMBOL_LEN - 1);
    localparam logic [ACC_W-1:0] THRESH    = ACC_W'(ASK_THRESH);
    localparam logic [3:0]       MODE_ASK  = 4'b1000;
    localparam logic [3:0]       MODE_BPSK = 4'b1010;
    localparam logic [3:0]       MODE_QPSK = 4'b1100;

    typedef enum logic [1:0] {IDLE, INTEG, DUMP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       mode_q_reg, mode_q_next;
    logic             start, take, tag_first, tag_last;

    logic             s1_valid_reg, s1_first_reg, s1_last_reg;
    logic [3:0]       s1_mode_reg;
    logic             dump_reg;
    logic [3:0]       dump_mode_reg;
    logic [1:0]       data_out_reg;
    logic             data_valid_reg, mode_err_reg;

    logic signed [11:0]      carrier [2];
    logic signed [ACC_W-1:0] sum_w   [2];
    logic [ACC_W-2:0]        abs_w   [2];
    logic [ACC_W-1:0]        mag;
    logic [1:0]              dec_bits;
    logic                    dec_ok, dec_err;

    assign start = sym_start & sample_valid;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mode_q_next = mode_q_reg;
        take        = 1'b0;
        tag_first   = 1'b0;
        tag_last    = 1'b0;
        case (state_reg)
            INTEG: begin
                // A new sym_start mid-symbol abandons the partial sums.
                if (start) begin
                    cnt_next    = CNT_W'(1);
                    mode_q_next = mode;
                    take        = 1'b1;
                    tag_first   = 1'b1;
                end else if (sample_valid) begin
                    take = 1'b1;
                    if (cnt_reg == LAST_IDX) begin
                        tag_last   = 1'b1;
                        cnt_next   = '0;
                        state_next = DUMP;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                if (start) begin
                    state_next  = INTEG;
                    cnt_next    = CNT_W'(1);
                    mode_q_next = mode;
                    take        = 1'b1;
                    tag_first   = 1'b1;
                end
            end
        endcase
    end

    assign carrier[0] = ref_cos;
    assign carrier[1] = ref_sin;

    // Channel 0 is the in-phase (cos) correlator, channel 1 the quadrature (sin) one.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic signed [23:0]      prod_reg;
        logic signed [ACC_W-1:0] acc_reg, sum_reg, prod_ext, total;
        logic [ACC_W-1:0]        neg;

        assign prod_ext = {{(ACC_W-24){prod_reg[23]}}, prod_reg};
        assign total    = (s1_first_reg ? '0 : acc_reg) + prod_ext;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                prod_reg <= '0;
                acc_reg  <= '0;
                sum_reg  <= '0;
            end else if (en) begin
                if (take)
                    prod_reg <= 24'(wave) * 24'(carrier[gi]);
                if (s1_valid_reg) begin
                    if (s1_last_reg) begin
                        sum_reg <= total;
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= total;
                    end
                end
            end
        end

        // Magnitude saturates so the most negative sum cannot wrap.
        assign neg        = -sum_reg;
        assign abs_w[gi]  = !sum_reg[ACC_W-1] ? sum_reg[ACC_W-2:0] :
                            (neg[ACC_W-1] ? '1 : neg[ACC_W-2:0]);
        assign sum_w[gi]  = sum_reg;
    end

    assign mag = {1'b0, abs_w[0]} + {1'b0, abs_w[1]};

    always_comb begin
        dec_bits = data_out_reg;
        dec_ok   = 1'b0;
        dec_err  = 1'b0;
        case (dump_mode_reg)
            MODE_ASK: begin
                dec_bits = {1'b0, mag >= THRESH};
                dec_ok   = 1'b1;
            end
            MODE_BPSK: begin
                dec_bits = {1'b0, sum_w[1][ACC_W-1]};
                dec_ok   = 1'b1;
            end
            MODE_QPSK: begin
                dec_bits = {sum_w[0][ACC_W-1], sum_w[1][ACC_W-1]};
                dec_ok   = 1'b1;
            end
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mode_q_reg     <= '0;
            s1_valid_reg   <= 1'b0;
            s1_first_reg   <= 1'b0;
            s1_last_reg    <= 1'b0;
            s1_mode_reg    <= '0;
            dump_reg       <= 1'b0;
            dump_mode_reg  <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            mode_err_reg   <= 1'b0;
        end else if (en) begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mode_q_reg   <= mode_q_next;
            s1_valid_reg <= take;
            s1_first_reg <= tag_first;
            s1_last_reg  <= tag_last;
            // The symbol's mode travels with its last product so a gapless
            // follow-on symbol can re-latch mode_q without disturbing it.
            if (tag_last)
                s1_mode_reg <= mode_q_reg;
            dump_reg <= s1_valid_reg & s1_last_reg;
            if (s1_valid_reg & s1_last_reg)
                dump_mode_reg <= s1_mode_reg;
            data_valid_reg <= dump_reg & dec_ok;
            mode_err_reg   <= dump_reg & dec_err;
            if (dump_reg & dec_ok)
                data_out_reg <= dec_bits;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg & en;
    assign mode_err   = mode_err_reg & en;

endmodule

// File: tb/tb_dds_demod.sv
// Randomized scoreboard bench for dds_demod: symbols are correlated by a
// plain-arithmetic reference model and results compared as pulses appear.
module tb_dds_demod;

    localparam int     SYMBOL_LEN = 300;
    localparam int     ACC_W      = 40;
    localparam longint ASK_THRESH = 268435456;
    localparam logic [3:0] M_ASK  = 4'b1000;
    localparam logic [3:0] M_BPSK = 4'b1010;
    localparam logic [3:0] M_QPSK = 4'b1100;
    localparam logic [3:0] M_BAD  = 4'b0011;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic [3:0]         mode = 4'b0;
    logic               sym_start = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [11:0] wave = '0;
    logic signed [11:0] ref_sin = '0;
    logic signed [11:0] ref_cos = '0;
    logic [1:0]         data_out;
    logic               data_valid;
    logic               mode_err;

    always #5 clk = ~clk;

    dds_demod #(
        .SYMBOL_LEN(SYMBOL_LEN),
        .ACC_W     (ACC_W),
        .ASK_THRESH(ASK_THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .sym_start   (sym_start),
        .sample_valid(sample_valid),
        .wave        (wave),
        .ref_sin     (ref_sin),
        .ref_cos     (ref_cos),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .mode_err    (mode_err)
    );

    typedef struct {
        bit         is_err;
        logic [1:0] data;
        longint     t;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    longint     last_edge = 0;
    int         ph = 0;
    int         cos_t[20];
    int         sin_t[20];
    logic [1:0] last_data = 2'b00;

    function automatic void check(string name, longint act, longint req);
        n_total++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endfunction

    function automatic int clamp12(int v);
        return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    endfunction

    function automatic int rand_wave();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    function automatic longint labs(longint v);
        return (v < 0) ? -v : v;
    endfunction

    // One clock: present inputs, let the rising edge take them, return at edge+1.
    task automatic drive(input logic sv, input logic ss, input int w);
        sample_valid = sv;
        sym_start    = ss;
        wave         = 12'(w);
        ref_cos      = 12'(cos_t[ph]);
        ref_sin      = 12'(sin_t[ph]);
        @(posedge clk);
        last_edge = $time;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            mode = 4'($urandom_range(15));
            drive(1'($urandom_range(1)), 1'b0, rand_wave());
        end
    endtask

    task automatic send_symbol(input logic [3:0] m, input real a_cos, input real a_sin,
                               input int n_samp = SYMBOL_LEN,
                               input int gap_at = -1, input int gap_len = 0,
                               input int sw_at = -1, input logic [3:0] sw_mode = 4'b0,
                               input int pause_at = -1, input int pause_len = 0);
        longint si = 0;
        longint sq = 0;
        int     w;
        exp_t   e;
        for (int n = 0; n < n_samp; n++) begin
            if (n == gap_at)
                repeat (gap_len) drive(1'b0, 1'b0, rand_wave());
            if (n == pause_at) begin
                en = 1'b0;
                repeat (pause_len) drive(1'b1, 1'($urandom_range(1)), rand_wave());
                en = 1'b1;
            end
            mode = (sw_at >= 0 && n >= sw_at) ? sw_mode : m;
            w = clamp12(int'(a_cos * cos_t[ph] + a_sin * sin_t[ph])
                        + int'($urandom_range(16)) - 8);
            si += longint'(w) * cos_t[ph];
            sq += longint'(w) * sin_t[ph];
            drive(1'b1, n == 0, w);
            ph = (ph + 1) % 20;
        end
        if (n_samp == SYMBOL_LEN) begin
            e.is_err = 1'b0;
            e.t      = last_edge + 25;
            case (m)
                M_ASK:   e.data = {1'b0, (labs(si) + labs(sq)) >= ASK_THRESH};
                M_BPSK:  e.data = {1'b0, sq < 0};
                M_QPSK:  e.data = {si < 0, sq < 0};
                default: begin
                    e.is_err = 1'b1;
                    e.data   = last_data;
                end
            endcase
            if (!e.is_err)
                last_data = e.data;
            exp_q.push_back(e);
        end
    endtask

    task automatic qpsk(input logic [1:0] d, input int pause_at = -1, input int pause_len = 0);
        send_symbol(M_QPSK, d[1] ? -0.7 : 0.7, d[0] ? -0.7 : 0.7, SYMBOL_LEN,
                    -1, 0, -1, 4'b0, pause_at, pause_len);
    endtask

    // Monitor: every pulse consumes the oldest expectation.
    always @(negedge clk) begin
        exp_t it;
        if (rst && (data_valid || mode_err)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got data_valid=%0b mode_err=%0b data_out=%0d, required no pulse (t=%0t)",
                         data_valid, mode_err, data_out, $time);
            end else begin
                it = exp_q.pop_front();
                $display("pulse t=%0t valid=%0b err=%0b data_out=%0d (model %0d)",
                         $time, data_valid, mode_err, data_out, it.data);
                check("pulse_kind", {data_valid, mode_err}, it.is_err ? 2'b01 : 2'b10);
                check("data_out", data_out, it.data);
                check("latency", $time, it.t);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d results outstanding", exp_q.size());
        $fatal(1);
    end

    initial begin
        int         mi, ga, gl;
        logic [1:0] d;
        for (int i = 0; i < 20; i++) begin
            cos_t[i] = int'(2047.0 * $cos(2.0 * 3.14159265358979 * i / 20.0));
            sin_t[i] = int'(2047.0 * $sin(2.0 * 3.14159265358979 * i / 20.0));
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b1;
        idle(1000);
        check("idle_data_out", data_out, 0);
        check("idle_data_valid", data_valid, 0);
        check("idle_mode_err", mode_err, 0);

        // BPSK 0 then 1, gapless
        send_symbol(M_BPSK, 0.0, 1.0);
        send_symbol(M_BPSK, 0.0, -1.0);
        idle(5);

        // QPSK 0..3 gapless
        for (int k = 0; k < 4; k++) qpsk(2'(k));
        idle(5);

        // ASK off then full-scale on
        send_symbol(M_ASK, 0.0, 0.0);
        send_symbol(M_ASK, 0.0, 1.0);
        idle(5);

        // 50-cycle sample_valid gap mid-symbol
        send_symbol(M_BPSK, 0.0, -1.0, SYMBOL_LEN, 120, 50);
        // aborted symbol at sample 150, replaced by a QPSK symbol
        send_symbol(M_BPSK, 0.0, -1.0, 150);
        qpsk(2'b10);
        idle(3);
        // mode flips to QPSK at sample 100; QPSK-shaped wave must still decide as BPSK
        send_symbol(M_BPSK, -0.7, 0.7, SYMBOL_LEN, -1, 0, 100, M_QPSK);
        // enable held low for 20 cycles mid-symbol
        qpsk(2'b01, 200, 20);

        for (int k = 0; k < 8; k++) begin
            mi = $urandom_range(2);
            d  = 2'($urandom_range(3));
            ga = ($urandom_range(2) == 0) ? int'($urandom_range(298, 1)) : -1;
            gl = $urandom_range(20, 1);
            case (mi)
                0:       send_symbol(M_ASK, 0.0, d[0] ? 1.0 : 0.0, SYMBOL_LEN, ga, gl);
                1:       send_symbol(M_BPSK, 0.0, d[0] ? -1.0 : 1.0, SYMBOL_LEN, ga, gl);
                default: send_symbol(M_QPSK, d[1] ? -0.7 : 0.7, d[0] ? -0.7 : 0.7,
                                     SYMBOL_LEN, ga, gl);
            endcase
            if ($urandom_range(1) == 1)
                idle($urandom_range(5, 1));
        end

        // Unsupported mode after a known QPSK result, then async reset mid-symbol
        qpsk(2'b11);
        idle(10);
        send_symbol(M_BAD, 0.0, 1.0);
        idle(10);
        send_symbol(M_BPSK, 0.0, 1.0, 80);
        #2;
        rst = 1'b0;
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_mode_err", mode_err, 0);
        last_data = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(20);
        send_symbol(M_BPSK, 0.0, -1.0);

        for (int i = 0; i < 2000 && exp_q.size() > 0; i++)
            @(negedge clk);
        idle(5);
        check("results_outstanding", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
